// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: forwards operands into EX, inserts load-use / HI-LO bubbles, freezes or flushes.
// Latency 1 cycle ID->EX. stall_i freezes the EX register; flushes seen while frozen apply on release.
// Backpressure: id_stall_o holds PC and IF/ID; define HILO_FWD_EN to forward HI/LO instead of stalling.
module id_ex_stage_reg #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int AOPW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            load_use_i,
    input  logic            r1_ex_i,
    input  logic            r1_mem_i,
    input  logic            r2_ex_i,
    input  logic            r2_mem_i,
    input  logic            hi_ex_i,
    input  logic            hi_mem_i,
    input  logic            lo_ex_i,
    input  logic            lo_mem_i,
    input  logic [DW-1:0]   zdx_ex_i,
    input  logic [DW-1:0]   zdx_mem_i,
    input  logic [DW-1:0]   rf_rdata1_i,
    input  logic [DW-1:0]   rf_rdata2_i,
    input  logic [DW-1:0]   hi_rdata_i,
    input  logic [DW-1:0]   lo_rdata_i,
    input  logic            id_valid_i,
    input  logic [DW-1:0]   id_pc_i,
    input  logic [DW-1:0]   id_imm_i,
    input  logic            id_regwrite_i,
    input  logic            id_hiwrite_i,
    input  logic            id_lowrite_i,
    input  logic            id_load_i,
    input  logic            id_jal_i,
    input  logic            id_hi_used_i,
    input  logic            id_lo_used_i,
    input  logic [RW-1:0]   id_wbregnum_i,
    input  logic [AOPW-1:0] id_aluop_i,
    output logic            ex_valid_o,
    output logic            ex_regwrite_o,
    output logic            ex_hiwrite_o,
    output logic            ex_lowrite_o,
    output logic            ex_load_o,
    output logic            ex_jal_o,
    output logic [RW-1:0]   ex_wbregnum_o,
    output logic [AOPW-1:0] ex_aluop_o,
    output logic [DW-1:0]   ex_pc_o,
    output logic [DW-1:0]   ex_imm_o,
    output logic [DW-1:0]   ex_op1_o,
    output logic [DW-1:0]   ex_op2_o,
    output logic [DW-1:0]   ex_hilo_o,
    output logic            id_stall_o,
    output logic [CNTW-1:0] bubble_cnt_o
);

    logic [DW-1:0] op1_fwd;
    logic [DW-1:0] op2_fwd;
    logic [DW-1:0] hilo_sel;
    logic          hilo_hz;
    logic          hz;
    logic          flush_pend;
    logic          kill;
    logic          take_id;

    // EX-stage result is younger than MEM, so it wins when both match
    always_comb begin
        op1_fwd = r1_ex_i ? zdx_ex_i : (r1_mem_i ? zdx_mem_i : rf_rdata1_i);
        op2_fwd = r2_ex_i ? zdx_ex_i : (r2_mem_i ? zdx_mem_i : rf_rdata2_i);
    end

`ifdef HILO_FWD_EN
    logic [DW-1:0] hi_fwd;
    logic [DW-1:0] lo_fwd;

    always_comb begin
        hi_fwd   = hi_ex_i ? zdx_ex_i : (hi_mem_i ? zdx_mem_i : hi_rdata_i);
        lo_fwd   = lo_ex_i ? zdx_ex_i : (lo_mem_i ? zdx_mem_i : lo_rdata_i);
        hilo_sel = id_hi_used_i ? hi_fwd : lo_fwd;
        hilo_hz  = 1'b0;
    end
`else
    // Without HI/LO forwarding, any in-flight producer forces ID to wait for retirement
    always_comb begin
        hilo_sel = id_hi_used_i ? hi_rdata_i : lo_rdata_i;
        hilo_hz  = (id_hi_used_i & (hi_ex_i | hi_mem_i)) |
                   (id_lo_used_i & (lo_ex_i | lo_mem_i));
    end
`endif

    always_comb begin
        hz         = load_use_i | hilo_hz;
        id_stall_o = stall_i | hz;
        kill       = flush_i | flush_pend;
        take_id    = ~kill & ~hz & id_valid_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend    <= 1'b0;
            bubble_cnt_o  <= '0;
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_hiwrite_o  <= 1'b0;
            ex_lowrite_o  <= 1'b0;
            ex_load_o     <= 1'b0;
            ex_jal_o      <= 1'b0;
            ex_wbregnum_o <= '0;
            ex_aluop_o    <= '0;
            ex_pc_o       <= '0;
            ex_imm_o      <= '0;
            ex_op1_o      <= '0;
            ex_op2_o      <= '0;
            ex_hilo_o     <= '0;
        end else if (stall_i) begin
            if (flush_i) begin
                flush_pend <= 1'b1;
            end
        end else begin
            flush_pend    <= 1'b0;
            ex_valid_o    <= take_id;
            ex_regwrite_o <= take_id & id_regwrite_i;
            ex_hiwrite_o  <= take_id & id_hiwrite_i;
            ex_lowrite_o  <= take_id & id_lowrite_i;
            ex_load_o     <= take_id & id_load_i;
            ex_jal_o      <= take_id & id_jal_i;
            ex_wbregnum_o <= take_id ? id_wbregnum_i : '0;
            ex_aluop_o    <= take_id ? id_aluop_i    : '0;
            ex_pc_o       <= take_id ? id_pc_i       : '0;
            ex_imm_o      <= take_id ? id_imm_i      : '0;
            ex_op1_o      <= take_id ? op1_fwd       : '0;
            ex_op2_o      <= take_id ? op2_fwd       : '0;
            ex_hilo_o     <= take_id ? hilo_sel      : '0;
            // Only hazard bubbles are counted; a flush in the same cycle takes precedence
            if (!kill && hz && (bubble_cnt_o != '1)) begin
                bubble_cnt_o <= bubble_cnt_o + CNTW'(1);
            end
        end
    end

endmodule
